data_mem_unit: RTL
==================

# data_mem_unit

Data-side memory subsystem sitting directly downstream of the pipelined processor's memory stages. It answers the processor's data bus (`DataAddr`, `DataOut`, `ReadData`, `WriteData`) with registered `DataIn`/`DataDone` one cycle later, matching the Memory1→Memory2 split. It decodes a fixed address map into local RAM, memory-mapped LED/switch/cycle-counter registers, and a posted-write window that drains through a small FIFO to an external peripheral handshake port.

## Interface
Parameters:
- `WORD_SIZE`, 16, data/address width
- `RAM_DEPTH`, 256, RAM words (power of 2)
- `FIFO_DEPTH`, 4, posted-write queue entries (power of 2)
- `IO_BITS`, 10, width of LED and switch registers

Ports:
- `Clock` in 1: single clock; all logic on posedge
- `Reset` in 1: synchronous, active-high
- `DataAddr` in WORD_SIZE: word address from processor
- `DataOut` in WORD_SIZE: processor write data
- `ReadData` in 1: read request this cycle
- `WriteData` in 1: write request this cycle
- `DataIn` out WORD_SIZE: read data to processor
- `DataDone` out 1: request sampled on previous edge completed
- `SW` in IO_BITS: asynchronous switch inputs
- `LEDR` out IO_BITS: LED register
- `PeriphValid` out 1, `PeriphReady` in 1: posted-write handshake
- `PeriphAddr` out WORD_SIZE, `PeriphData` out WORD_SIZE: head-of-FIFO entry
- `BusError` out 1: sticky error flag

## Operation
- Address map (`DataAddr[15:12]`): 0x0 RAM (index = low log2(RAM_DEPTH) bits, upper bits alias); 0x1 LEDR (R/W, low IO_BITS, upper bits read 0); 0x2 cycle counter (R/W); 0x3 SW (read-only, writes ignored); 0x4–0x7 peripheral window (write-posted, reads return 0); 0x8–0xF unmapped.
- RAM: synchronous, read-before-write; contents not reset.
- Cycle counter: +1 every cycle, wraps 0xFFFF→0x0000; a write loads `DataOut` and suppresses that cycle's increment; a read returns the value before that edge's update.
- SW: two-flop synchronizer; reads return the synchronized value.
- Peripheral write: {DataAddr, DataOut} pushed into FIFO if not full. Full test uses the registered count; a pop in the same cycle does not free space. Refused write: no side effect, `DataDone`=0 next cycle (processor must retry).
- FIFO output: `PeriphValid` = not empty; entry popped on `PeriphValid && PeriphReady`; no fall-through (push into empty FIFO → `PeriphValid` next cycle). Addr/Data stable while Valid && !Ready.
- Unmapped access, or `ReadData && WriteData` together: `BusError` set (sticky until Reset); both-high performed as write only, `DataIn`=0; unmapped reads return 0, writes dropped; `DataDone`=1 in both cases.

## Timing
- Request sampled at edge N; `DataIn`, `DataDone` valid for cycle N+1 only (one-cycle pulse per request). Back-to-back requests every cycle supported.
- `DataIn` = 0 in any cycle where `DataDone`=0 or the completed request was a write.
- Reset (synchronous): `DataIn`=0, `DataDone`=0, `LEDR`=0, counter=0, FIFO empty (`PeriphValid`=0, `PeriphAddr`/`PeriphData`=0), `BusError`=0, sync flops 0. A request sampled on the reset edge is dropped; `DataDone`=0 the next cycle.
- LEDR write visible on `LEDR` at N+1.

## Structure
- Package `mem_map_pkg`: region enum {RAM, LED, CNT, SW, PERIPH, UNMAPPED}, region base constants, decode function on `DataAddr[15:12]`.
- Submodule `post_fifo`: parameterized synchronous FIFO (WIDTH, DEPTH), push/pop/full/empty/count, synchronous active-high reset.
- Top: decoder, response register, RAM array, LED/counter/SW registers, error flag.

## Test plan
- RAM write 0x0005←0xBEEF, then read 0x0005 → `DataDone`=1 both, `DataIn`=0xBEEF on cycle after read; read 0x0105 (alias, RAM_DEPTH=256) → 0xBEEF.
- Write 0x1000←0xFFFF → `LEDR`=0x3FF next cycle; read 0x1000 → 0x03FF.
- Write 0x2000←0xFFFE, idle 2 cycles, read 0x2000 → 0x0000 (wrap); `SW`=0x155 held 3 cycles, read 0x3000 → 0x0155.
- `PeriphReady`=0, five writes to 0x4000..0x4004 → first four `DataDone`=1, fifth `DataDone`=0; raise Ready → entries emerge in order, `PeriphValid` drops after fourth.
- Read 0x9000 → `DataIn`=0, `DataDone`=1, `BusError`=1 and stays 1 until Reset.
- Assert Reset on edge with pending read of 0x0005 → `DataDone`=0 next cycle, all outputs 0, RAM still holds 0xBEEF afterward.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Address map of the data-side memory unit: region codes and the decode of the
// top address nibble into a region.
package mem_map_pkg;

   typedef enum logic [2:0] {
      REGION_RAM,
      REGION_LED,
      REGION_CNT,
      REGION_SW,
      REGION_PERIPH,
      REGION_UNMAPPED
   } region_e;

   localparam logic [3:0] RAM_BASE    = 4'h0;
   localparam logic [3:0] LED_BASE    = 4'h1;
   localparam logic [3:0] CNT_BASE    = 4'h2;
   localparam logic [3:0] SW_BASE     = 4'h3;
   localparam logic [3:0] PERIPH_BASE = 4'h4;
   localparam logic [3:0] PERIPH_LAST = 4'h7;

   function automatic region_e decode_region(input logic [3:0] nib);
      region_e r;
      if (nib == RAM_BASE)                                r = REGION_RAM;
      else if (nib == LED_BASE)                           r = REGION_LED;
      else if (nib == CNT_BASE)                           r = REGION_CNT;
      else if (nib == SW_BASE)                            r = REGION_SW;
      else if (nib >= PERIPH_BASE && nib <= PERIPH_LAST)  r = REGION_PERIPH;
      else                                                r = REGION_UNMAPPED;
      return r;
   endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Processor data bus: request (address, write data, read/write strobes) and the
// registered one-cycle-later response (read data, done).
interface data_mem_unit_if #(parameter int WORD_SIZE = 16);

   logic [WORD_SIZE-1:0] DataAddr;
   logic [WORD_SIZE-1:0] DataOut;
   logic                 ReadData;
   logic                 WriteData;
   logic [WORD_SIZE-1:0] DataIn;
   logic                 DataDone;

   modport master (
      output DataAddr, DataOut, ReadData, WriteData,
      input  DataIn, DataDone
   );

   modport slave (
      input  DataAddr, DataOut, ReadData, WriteData,
      output DataIn, DataDone
   );

endinterface

// File: rtl/post_fifo.sv
// Posted-write queue: synchronous FIFO with registered head (no fall-through).
// Push ignored while full by registered count; pop ignored while empty.
module post_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_en, pop_en;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   // Head reads as zero when empty so stale storage never leaks out after reset.
   assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= push_dat;
   end

endmodule

// File: rtl/data_mem_unit.sv
// Data-side memory unit: RAM, LED/counter/switch registers and a posted peripheral window.
// Response registered one cycle after the request; a store to a full peripheral FIFO is refused (DataDone=0).
module data_mem_unit
   import mem_map_pkg::*;
#(
   parameter int WORD_SIZE  = 16,
   parameter int RAM_DEPTH  = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int IO_BITS    = 10
) (
   input  logic                 Clock,
   input  logic                 Reset,
   data_mem_unit_if.slave       bus,
   input  logic [IO_BITS-1:0]   SW,
   output logic [IO_BITS-1:0]   LEDR,
   output logic                 PeriphValid,
   input  logic                 PeriphReady,
   output logic [WORD_SIZE-1:0] PeriphAddr,
   output logic [WORD_SIZE-1:0] PeriphData,
   output logic                 BusError
);

   localparam int RAM_AW = $clog2(RAM_DEPTH);
   localparam int FIFO_W = 2 * WORD_SIZE;

   region_e              region;
   logic                 rd_req, wr_req, both_req, periph_req;
   logic                 periph_push, periph_pop, fifo_full, fifo_empty;
   logic                 ram_we;
   logic [RAM_AW-1:0]    ram_idx;
   logic [FIFO_W-1:0]    fifo_head;
   logic [WORD_SIZE-1:0] ram_q [RAM_DEPTH];
   logic [WORD_SIZE-1:0] rd_val;
   logic [WORD_SIZE-1:0] din_q, din_d, cnt_q, cnt_d;
   logic                 done_q, done_d, err_q, err_d;
   logic [IO_BITS-1:0]   led_q, led_d, sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;

   assign region      = decode_region(bus.DataAddr[WORD_SIZE-1 -: 4]);
   assign ram_idx     = bus.DataAddr[RAM_AW-1:0];
   // Read+write together is carried out as a write only.
   assign both_req    = bus.ReadData && bus.WriteData;
   assign wr_req      = bus.WriteData;
   assign rd_req      = bus.ReadData && !bus.WriteData;
   assign periph_req  = wr_req && (region == REGION_PERIPH);
   assign periph_push = periph_req && !fifo_full;
   assign periph_pop  = PeriphValid && PeriphReady;
   assign ram_we      = wr_req && (region == REGION_RAM) && !Reset;

   always_comb begin
      rd_val = '0;
      case (region)
         REGION_RAM: rd_val = ram_q[ram_idx];
         REGION_LED: rd_val = WORD_SIZE'(led_q);
         REGION_CNT: rd_val = cnt_q;
         REGION_SW:  rd_val = WORD_SIZE'(sw_sync_q);
         default:    rd_val = '0;
      endcase
      din_d     = rd_req ? rd_val : '0;
      done_d    = (rd_req || wr_req) && !(periph_req && fifo_full);
      led_d     = (wr_req && region == REGION_LED) ? bus.DataOut[IO_BITS-1:0] : led_q;
      cnt_d     = (wr_req && region == REGION_CNT) ? bus.DataOut : cnt_q + WORD_SIZE'(1);
      err_d     = err_q || both_req || ((rd_req || wr_req) && region == REGION_UNMAPPED);
      sw_meta_d = SW;
      sw_sync_d = sw_meta_q;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         din_q     <= '0;
         done_q    <= 1'b0;
         led_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         din_q     <= din_d;
         done_q    <= done_d;
         led_q     <= led_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (ram_we) ram_q[ram_idx] <= bus.DataOut;
   end

   post_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_post_fifo (
      .clk      (Clock),
      .rst      (Reset),
      .push     (periph_push),
      .push_dat ({bus.DataAddr, bus.DataOut}),
      .pop      (periph_pop),
      .pop_dat  (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign bus.DataIn               = din_q;
   assign bus.DataDone             = done_q;
   assign LEDR                     = led_q;
   assign BusError                 = err_q;
   assign PeriphValid              = !fifo_empty;
   assign {PeriphAddr, PeriphData} = fifo_head;

endmodule
